// File: rtl/rob_regfile_if.sv
// Dispatch, commit, ROB-window, flush and operand-lookup bundle between the ROB and rob_regfile.
// master = ROB/dispatch side, slave = register file.
interface rob_regfile_if #(
  parameter int WIDTH    = 32,
  parameter int ROB_SIZE = 8,
  parameter int TAG_W    = 4
);
  logic                               reg_ld_instr;
  logic [4:0]                         disp_rd;
  logic [TAG_W-1:0]                   rd_tag;
  logic [ROB_SIZE-1:0]                cm_rdy;
  logic [ROB_SIZE-1:0][TAG_W-1:0]     cm_tag;
  logic [ROB_SIZE-1:0][4:0]           cm_rd;
  logic [ROB_SIZE-1:0][WIDTH-1:0]     cm_data;
  logic [ROB_SIZE-1:0][4:0]           rob_rd;
  logic [ROB_SIZE-1:0]                rob_wr;
  logic                               flush_valid;
  logic [TAG_W-1:0]                   flush_tag;
  logic [TAG_W-1:0]                   front_tag;
  logic [4:0]                         rs1;
  logic [4:0]                         rs2;
  logic [WIDTH-1:0]                   rs1_data;
  logic [WIDTH-1:0]                   rs2_data;
  logic                               rs1_busy;
  logic                               rs2_busy;
  logic [TAG_W-1:0]                   rs1_tag;
  logic [TAG_W-1:0]                   rs2_tag;

  modport master (
    output reg_ld_instr, disp_rd, rd_tag,
    output cm_rdy, cm_tag, cm_rd, cm_data,
    output rob_rd, rob_wr, flush_valid, flush_tag, front_tag,
    output rs1, rs2,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );

  modport slave (
    input  reg_ld_instr, disp_rd, rd_tag,
    input  cm_rdy, cm_tag, cm_rd, cm_data,
    input  rob_rd, rob_wr, flush_valid, flush_tag, front_tag,
    input  rs1, rs2,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );
endinterface

// File: rtl/rob_regfile.sv
// Architectural register file with per-register rename status (busy + ROB tag) and flush rebuild.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle commits to the operand lookups.
module rob_regfile #(
  parameter int WIDTH    = 32,
  parameter int ROB_SIZE = 8,
  parameter int TAG_W    = 4
) (
  input logic          clk,
  input logic          rst,
  rob_regfile_if.slave bus
);
  // ROB_SIZE is a power of two, so slot index and age arithmetic wrap by truncation.
  localparam int SLOT_W = $clog2(ROB_SIZE);

  typedef logic [SLOT_W-1:0] slot_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             busy;
    logic [TAG_W-1:0] tag;
  } rd_t;

  logic [31:0][WIDTH-1:0]         data_q, data_d;
  logic [31:0]                    busy_q, busy_d;
  logic [31:0][TAG_W-1:0]         tag_q, tag_d;

  logic [ROB_SIZE-1:0]            cm_rdy;
  logic [ROB_SIZE-1:0][TAG_W-1:0] cm_tag;
  logic [ROB_SIZE-1:0][4:0]       cm_rd;
  logic [ROB_SIZE-1:0][WIDTH-1:0] cm_data;
  slot_t                          front_slot;

  assign cm_rdy     = bus.cm_rdy;
  assign cm_tag     = bus.cm_tag;
  assign cm_rd      = bus.cm_rd;
  assign cm_data    = bus.cm_data;
  assign front_slot = bus.front_tag[SLOT_W-1:0];

  always_comb begin
    logic [ROB_SIZE-1:0] committing;
    slot_t               flush_age;
    slot_t               best_age;
    slot_t               lane_age;
    slot_t               slot;
    logic                found;

    data_d     = data_q;
    busy_d     = busy_q;
    tag_d      = tag_q;
    committing = '0;
    best_age   = '0;
    lane_age   = '0;
    slot       = '0;
    found      = 1'b0;
    flush_age  = bus.flush_tag[SLOT_W-1:0] - front_slot;

    for (int r = 1; r < 32; r++) begin
      best_age = '0;
      found    = 1'b0;
      for (int l = 0; l < ROB_SIZE; l++) begin
        if (cm_rdy[l] && cm_rd[l] == 5'(r)) begin
          lane_age = cm_tag[l][SLOT_W-1:0] - front_slot;
          if (!found || lane_age >= best_age) begin
            data_d[r] = cm_data[l];
            best_age  = lane_age;
            found     = 1'b1;
          end
          if (cm_tag[l] == tag_q[r]) busy_d[r] = 1'b0;
        end
      end
    end

    for (int l = 0; l < ROB_SIZE; l++) begin
      if (cm_rdy[l]) committing[cm_tag[l][SLOT_W-1:0]] = 1'b1;
    end

    // Walk the surviving window oldest to youngest so the youngest producer lands last.
    if (bus.flush_valid) begin
      busy_d = '0;
      tag_d  = '0;
      for (int k = 0; k < ROB_SIZE; k++) begin
        slot = front_slot + SLOT_W'(k);
        if (SLOT_W'(k) < flush_age && bus.rob_wr[slot] && !committing[slot] &&
            bus.rob_rd[slot] != 5'd0) begin
          busy_d[bus.rob_rd[slot]] = 1'b1;
          tag_d[bus.rob_rd[slot]]  = bus.front_tag + TAG_W'(k);
        end
      end
    end else if (bus.reg_ld_instr && bus.disp_rd != 5'd0) begin
      busy_d[bus.disp_rd] = 1'b1;
      tag_d[bus.disp_rd]  = bus.rd_tag;
    end

    data_d[0] = '0;
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  function automatic rd_t lookup(input logic [4:0] rs);
    rd_t res;
`ifdef REGFILE_BYPASS_EN
    slot_t best;
    slot_t age;
    logic  hit;
`endif
    res.data = data_q[rs];
    res.busy = busy_q[rs];
    res.tag  = tag_q[rs];
`ifdef REGFILE_BYPASS_EN
    best = '0;
    age  = '0;
    hit  = 1'b0;
    if (busy_q[rs]) begin
      for (int l = 0; l < ROB_SIZE; l++) begin
        if (cm_rdy[l] && cm_tag[l] == tag_q[rs]) begin
          age = cm_tag[l][SLOT_W-1:0] - front_slot;
          if (!hit || age >= best) begin
            res.data = cm_data[l];
            res.busy = 1'b0;
            best     = age;
            hit      = 1'b1;
          end
        end
      end
    end
`endif
    if (rs == 5'd0) res = '0;
    return res;
  endfunction

  rd_t rd1, rd2;

  assign rd1 = lookup(bus.rs1);
  assign rd2 = lookup(bus.rs2);

  assign bus.rs1_data = rd1.data;
  assign bus.rs1_busy = rd1.busy;
  assign bus.rs1_tag  = rd1.tag;
  assign bus.rs2_data = rd2.data;
  assign bus.rs2_busy = rd2.busy;
  assign bus.rs2_tag  = rd2.tag;
endmodule
